dtmf_digit_collector: RTL

- Downstream stage of the DTMF tone detector. Consumes one tone result per FFT frame.
- Debounces the result: a digit must persist ON_FRAMES frames to be accepted.
- Suppresses repeats while a key is held. Requires OFF_FRAMES silent frames to release.
- Queues accepted digits in a small FIFO. The FIFO is drained by the control/display logic through a valid/ready handshake.

---
 rtl/dtmf_digit_collector_if.sv | 27 ++
 rtl/dtmf_digit_collector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dtmf_digit_collector_if.sv
// Digit collector bus: tone-detector input strobe, digit-queue handshake
// and status. The "slave" modport is the collector; "master" is its environment.
interface dtmf_digit_collector_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          tone_valid;
  logic [15:0]   tone_code;
  logic          out_valid;
  logic [3:0]    out_digit;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic          key_active;
  logic          overflow;
  logic          clear_overflow;

  modport slave (
    input  tone_valid, tone_code, out_ready, clear_overflow,
    output out_valid, out_digit, fifo_count, key_active, overflow
  );

  modport master (
    output tone_valid, tone_code, out_ready, clear_overflow,
    input  out_valid, out_digit, fifo_count, key_active, overflow
  );
endinterface

// File: rtl/dtmf_digit_collector.sv
// DTMF digit collector: debounces per-frame tone results, suppresses
// repeats while a key is held, and queues accepted digits in a small FIFO
// drained by a valid/ready consumer.
module dtmf_digit_collector #(
  parameter int ON_FRAMES  = 3,
  parameter int OFF_FRAMES = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  dtmf_digit_collector_if.slave         bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]    ON_L   = ON_FRAMES[3:0];
  localparam logic [3:0]    OFF_L  = OFF_FRAMES[3:0];
  localparam logic [CW-1:0] FULL_L = FIFO_DEPTH[CW-1:0];
  localparam bit            ON_ONE = (ON_FRAMES == 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    cand;
  logic [3:0]    on_cnt;
  logic [3:0]    off_cnt;
  logic          key_active;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    head;
  logic          out_valid;
  logic          overflow;

  logic [3:0]    digit;
  logic          is_tone;
  logic          same;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_do;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_next;

  assign digit   = bus.tone_code[3:0];
  assign is_tone = (bus.tone_code != 16'hFFFF);
  assign same    = (digit == cand);
  assign full    = (count == FULL_L);
  assign pop     = out_valid && bus.out_ready;
  // A push into a full queue only lands if the head leaves on the same edge.
  assign push_do = push_req && (!full || pop);
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  // Decide whether the frame sampled on this edge completes qualification.
  always_comb begin
    push_req = 1'b0;
    if (bus.tone_valid && is_tone) begin
      case (state)
        IDLE:    push_req = ON_ONE;
        QUALIFY: push_req = same ? (on_cnt + 4'd1 == ON_L) : ON_ONE;
        default: push_req = !same && ON_ONE;
      endcase
    end
  end

  // Entry count after this edge's push/pop.
  always_comb begin
    count_next = count;
    if (push_do && !pop)      count_next = count + 1'b1;
    else if (pop && !push_do) count_next = count - 1'b1;
  end

  // Debounce / hold / release state machine; only strobed frames advance it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= 4'd0;
      on_cnt     <= 4'd0;
      off_cnt    <= 4'd0;
      key_active <= 1'b0;
    end else if (bus.tone_valid) begin
      case (state)
        IDLE: begin
          if (is_tone) begin
            cand       <= digit;
            on_cnt     <= 4'd1;
            state      <= ON_ONE ? HELD : QUALIFY;
            key_active <= ON_ONE;
          end
        end
        QUALIFY: begin
          if (!is_tone) begin
            on_cnt <= 4'd0;
            state  <= IDLE;
          end else if (same) begin
            on_cnt <= on_cnt + 4'd1;
            if (on_cnt + 4'd1 == ON_L) begin
              state      <= HELD;
              key_active <= 1'b1;
            end
          end else begin
            cand       <= digit;
            on_cnt     <= 4'd1;
            state      <= ON_ONE ? HELD : QUALIFY;
            key_active <= ON_ONE;
          end
        end
        HELD, RELEASE: begin
          if (!is_tone) begin
            // Entering RELEASE starts the count at 1; in RELEASE it keeps counting.
            if ((state == HELD ? 4'd1 : off_cnt + 4'd1) == OFF_L) begin
              off_cnt    <= 4'd0;
              state      <= IDLE;
              key_active <= 1'b0;
            end else begin
              off_cnt <= (state == HELD) ? 4'd1 : off_cnt + 4'd1;
              state   <= RELEASE;
            end
          end else if (same) begin
            // Short dropout of the same key is bridged without a new push.
            off_cnt <= 4'd0;
            state   <= HELD;
          end else begin
            cand       <= digit;
            on_cnt     <= 4'd1;
            off_cnt    <= 4'd0;
            state      <= ON_ONE ? HELD : QUALIFY;
            key_active <= ON_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage: written only, the head register carries the read side.
  always_ff @(posedge clock) begin
    if (push_do) mem[wr_ptr] <= digit;
  end

  // Pointers, count, registered head/valid and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head      <= 4'd0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      // The next head is either already stored or being written right now.
      if (count_next != '0)
        head <= (push_do && wr_ptr == rd_next) ? digit : mem[rd_next];
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (bus.clear_overflow)  overflow <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_digit  = head;
  assign bus.fifo_count = count;
  assign bus.key_active = key_active;
  assign bus.overflow   = overflow;
endmodule
